rv32im_bus_arbiter: RTL and testbench

- Parametrised N-master Wishbone (classic) arbiter and bus multiplexer for the rv32im core family.
- Supports fixed-priority or round-robin arbitration, with grant held until the owner drops both req and cyc.
- Optional bus watchdog.
- Sits between core-internal masters (memory stage, prefetch, external controller, DMA) and the single system bus.

---
 rtl/rv32im_bus_arbiter_pkg.sv | 24 ++
 rtl/rv32im_bus_arbiter_if.sv | 57 +++++
 rtl/rv32im_bus_arbiter_rr_picker.sv | 37 +++
 rtl/rv32im_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_rv32im_bus_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32im_bus_arbiter_pkg.sv
// Shared constants for the rv32im N-master Wishbone arbiter:
// arbitration modes, FSM state encoding and bus width helpers.
package rv32im_bus_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam int DEF_XLEN = 32;
    localparam int ADR_W    = DEF_XLEN - 2;   // word addressed
    localparam int SEL_W    = DEF_XLEN / 8;

    // Width helpers for non-default XLEN builds
    function automatic int adr_w(input int xlen);
        return xlen - 2;
    endfunction

    function automatic int sel_w(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/rv32im_bus_arbiter_if.sv
// Bundle of the master-side and system-bus-side Wishbone signals around
// the arbiter. Master slices are flattened: master k occupies slice k.
interface rv32im_bus_arbiter_if
    import rv32im_bus_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int NUM_MASTERS = 3
);
    localparam int AW = adr_w(XLEN);
    localparam int SW = sel_w(XLEN);
    localparam int IW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]      req_i;
    logic [NUM_MASTERS-1:0]      grant_o;
    logic [NUM_MASTERS*AW-1:0]   m_adr_i;
    logic [NUM_MASTERS*XLEN-1:0] m_dat_i;
    logic [NUM_MASTERS*SW-1:0]   m_sel_i;
    logic [NUM_MASTERS-1:0]      m_cyc_i;
    logic [NUM_MASTERS-1:0]      m_stb_i;
    logic [NUM_MASTERS-1:0]      m_we_i;
    logic [XLEN-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]      m_ack_o;
    logic [NUM_MASTERS-1:0]      m_err_o;
    logic [AW-1:0]               s_adr_o;
    logic [XLEN-1:0]             s_dat_o;
    logic [SW-1:0]               s_sel_o;
    logic                        s_cyc_o;
    logic                        s_stb_o;
    logic                        s_we_o;
    logic [XLEN-1:0]             s_dat_i;
    logic                        s_ack_i;
    logic                        s_err_i;
    logic [IW-1:0]               owner_o;
    logic                        busy_o;

    // Arbiter view: sees every master and the slave, drives the muxed results
    modport arb (
        input  req_i, m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output grant_o, m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
        output owner_o, busy_o
    );

    // Requester side
    modport master (
        output req_i, m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
        input  grant_o, m_dat_o, m_ack_o, m_err_o, owner_o, busy_o
    );

    // System bus slave side
    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
        output s_dat_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/rv32im_bus_arbiter_rr_picker.sv
// Combinational winner picker: first set request at or after ptr,
// searching upward and wrapping. With ptr tied to 0 it is fixed priority.
module rv32im_rr_picker #(
    parameter int NUM_MASTERS = 3,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] win_oh,
    output logic [IW-1:0]          win_idx,
    output logic                   win_any
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    logic [IW-1:0]            pos;
    logic [IW:0]              sum;

    // Rotate so ptr lands at bit 0, take lowest set bit, rotate index back
    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[NUM_MASTERS-1:0];
        win_any = |req;
        pos     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot[k]) pos = IW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, pos};
        if (sum >= (IW+1)'(NUM_MASTERS)) sum = sum - (IW+1)'(NUM_MASTERS);
        win_idx = sum[IW-1:0];
        win_oh  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            win_oh[k] = win_any && (win_idx == IW'(k));
        end
    end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// N-master Wishbone classic arbiter and bus mux for the rv32im core family.
// Fixed-priority or round-robin; the owner keeps the bus until it drops
// both req and cyc, and a dead IDLE cycle always separates owners.
// Optional bus watchdog: define RV32IM_ARB_WATCHDOG_EN to add a stall
// counter that errors and force-releases a hung transfer (adds timeout_o).
module rv32im_bus_arbiter
    import rv32im_bus_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int NUM_MASTERS    = 3,
    parameter int ARB_MODE       = ARB_FIXED,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                reset_i,
    rv32im_bus_arbiter_if.arb   bus
`ifdef RV32IM_ARB_WATCHDOG_EN
    ,
    output logic                timeout_o
`endif
);

    localparam int NM = NUM_MASTERS;
    localparam int AW = adr_w(XLEN);
    localparam int SW = sel_w(XLEN);
    localparam int IW = $clog2(NUM_MASTERS);

    logic [0:0]    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IW-1:0] pick_ptr, win_idx, owner_next;
    logic [NM-1:0] win_oh;
    logic          win_any, busy, owner_rel, wd_fire;

    logic [AW-1:0]   s_adr;
    logic [XLEN-1:0] s_dat;
    logic [SW-1:0]   s_sel;
    logic            s_cyc, s_stb, s_we;

    assign busy = (state_q == ST_OWNED);

    // Fixed mode always searches from master 0
    assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    rv32im_rr_picker #(
        .NUM_MASTERS (NM),
        .IW          (IW)
    ) u_picker (
        .req     (bus.req_i),
        .ptr     (pick_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Owner gives up the bus only once both its req and cyc are low
    always_comb begin
        owner_rel  = ~bus.req_i[owner_q] & ~bus.m_cyc_i[owner_q];
        owner_next = (owner_q == IW'(NM - 1)) ? '0 : owner_q + 1'b1;
    end

    // Route the owner's request slice onto the system bus; quiet when idle
    always_comb begin
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we  = 1'b0;
        if (busy) begin
            s_adr = bus.m_adr_i[owner_q*AW +: AW];
            s_dat = bus.m_dat_i[owner_q*XLEN +: XLEN];
            s_sel = bus.m_sel_i[owner_q*SW +: SW];
            s_cyc = bus.m_cyc_i[owner_q];
            s_stb = bus.m_stb_i[owner_q];
            s_we  = bus.m_we_i[owner_q];
        end
    end

`ifdef RV32IM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_stall;

    // Count consecutive stalled strobes; fire on the TIMEOUT_CYCLES-th one
    always_comb begin
        wd_stall = busy & s_stb & ~bus.s_ack_i & ~bus.s_err_i;
        wd_fire  = wd_stall && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
        wd_cnt_d = (wd_stall && !wd_fire) ? wd_cnt_q + 1'b1 : '0;
    end

    // Watchdog counter register
    always_ff @(posedge clk_i) begin
        if (!reset_i) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end

    assign timeout_o = wd_fire;
`else
    assign wd_fire = 1'b0;
`endif

    // IDLE grants the picker winner; OWNED holds until release or timeout
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_OWNED;
                    grant_d = win_oh;
                    owner_d = win_idx;
                end
            end
            default: begin
                if (owner_rel || wd_fire) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    if (ARB_MODE == ARB_RR) rr_ptr_d = owner_next;
                end
            end
        endcase
    end

    // Arbiter state registers; reset abandons any transfer in flight
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.grant_o = grant_q;
    assign bus.owner_o = owner_q;
    assign bus.busy_o  = busy;
    assign bus.s_adr_o = s_adr;
    assign bus.s_dat_o = s_dat;
    assign bus.s_sel_o = s_sel;
    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_we_o  = s_we;
    assign bus.m_dat_o = bus.s_dat_i;
    // grant_q is one-hot on the owner while busy and zero otherwise
    assign bus.m_ack_o = grant_q & {NM{bus.s_ack_i & busy}};
    assign bus.m_err_o = grant_q & {NM{(bus.s_err_i & busy) | wd_fire}};

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed bench for rv32im_bus_arbiter: fixed-priority N=3, round-robin
// N=3 and round-robin N=5 instances share one clock and reset.
module tb_rv32im_bus_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;

    rv32im_bus_arbiter_if #(.XLEN(32), .NUM_MASTERS(3)) bf ();
    rv32im_bus_arbiter_if #(.XLEN(32), .NUM_MASTERS(3)) br ();
    rv32im_bus_arbiter_if #(.XLEN(32), .NUM_MASTERS(5)) b5 ();

`ifdef RV32IM_ARB_WATCHDOG_EN
    logic to_fix, to_rr, to_5;
`endif

    rv32im_bus_arbiter #(.XLEN(32), .NUM_MASTERS(3), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_fix (
        .clk_i(clk), .reset_i(rst_n), .bus(bf)
`ifdef RV32IM_ARB_WATCHDOG_EN
        , .timeout_o(to_fix)
`endif
    );

    rv32im_bus_arbiter #(.XLEN(32), .NUM_MASTERS(3), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_rr (
        .clk_i(clk), .reset_i(rst_n), .bus(br)
`ifdef RV32IM_ARB_WATCHDOG_EN
        , .timeout_o(to_rr)
`endif
    );

    rv32im_bus_arbiter #(.XLEN(32), .NUM_MASTERS(5), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_rr5 (
        .clk_i(clk), .reset_i(rst_n), .bus(b5)
`ifdef RV32IM_ARB_WATCHDOG_EN
        , .timeout_o(to_5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        bf.req_i = '0; bf.m_cyc_i = '0; bf.m_stb_i = '0; bf.m_we_i = '0;
        bf.m_adr_i = '0; bf.m_dat_i = '0; bf.m_sel_i = '0;
        bf.s_dat_i = '0; bf.s_ack_i = 1'b0; bf.s_err_i = 1'b0;
        br.req_i = '0; br.m_cyc_i = '0; br.m_stb_i = '0; br.m_we_i = '0;
        br.m_adr_i = '0; br.m_dat_i = '0; br.m_sel_i = '0;
        br.s_dat_i = '0; br.s_ack_i = 1'b0; br.s_err_i = 1'b0;
        b5.req_i = '0; b5.m_cyc_i = '0; b5.m_stb_i = '0; b5.m_we_i = '0;
        b5.m_adr_i = '0; b5.m_dat_i = '0; b5.m_sel_i = '0;
        b5.s_dat_i = '0; b5.s_ack_i = 1'b0; b5.s_err_i = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst_n   = 1'b0;
        clr_all();
        step(2);

        // ---- reset state
        check("rst_grant", bf.grant_o, 3'b000);
        check("rst_busy",  bf.busy_o,  1'b0);
        check("rst_owner", bf.owner_o, 2'd0);
        check("rst_scyc",  bf.s_cyc_o, 1'b0);
        check("rst_rr_grant", br.grant_o, 3'b000);
        rst_n = 1'b1;
        step(1);

        // ---- fixed: req 110 -> grant 010, release -> dead cycle -> 100
        bf.req_i = 3'b110; bf.m_cyc_i = 3'b110; bf.m_stb_i = 3'b110;
        #1 check("fix_lat0", bf.grant_o, 3'b000);
        step(1);
        check("fix_g1",    bf.grant_o, 3'b010);
        check("fix_own1",  bf.owner_o, 2'd1);
        check("fix_scyc",  bf.s_cyc_o, 1'b1);
        step(4);
        check("fix_hold",  bf.grant_o, 3'b010);
        bf.req_i[1] = 1'b0; bf.m_cyc_i[1] = 1'b0; bf.m_stb_i[1] = 1'b0;
        step(1);
        check("fix_dead",  bf.grant_o, 3'b000);
        check("fix_dead_busy", bf.busy_o, 1'b0);
        step(1);
        check("fix_g2",    bf.grant_o, 3'b100);
        check("fix_own2",  bf.owner_o, 2'd2);
        bf.req_i = '0; bf.m_cyc_i = '0; bf.m_stb_i = '0;
        step(1);
        check("fix_idle",  bf.grant_o, 3'b000);

        // ---- mux check with owner 0, master 2 also requesting
        bf.m_adr_i = {30'h3FFF_0000, 30'h0, 30'h0000_1234};
        bf.m_dat_i = {32'h1111_2222, 32'h0, 32'hDEAD_BEEF};
        bf.m_sel_i = {4'hF, 4'h0, 4'b0011};
        bf.m_we_i  = 3'b001;
        bf.req_i = 3'b101; bf.m_cyc_i = 3'b101; bf.m_stb_i = 3'b101;
        #1 check("mux_idle_adr", bf.s_adr_o, 30'h0);
        step(1);
        check("mux_grant", bf.grant_o, 3'b001);
        check("mux_adr",   bf.s_adr_o, 30'h0000_1234);
        check("mux_dat",   bf.s_dat_o, 32'hDEAD_BEEF);
        check("mux_sel",   bf.s_sel_o, 4'b0011);
        check("mux_we",    bf.s_we_o,  1'b1);
        check("mux_stb",   bf.s_stb_o, 1'b1);
        bf.m_dat_i[64 +: 32] = 32'h5555_5555;
        bf.m_adr_i[60 +: 30] = 30'h0ABC_DEF0;
        #1 check("mux_nonown_dat", bf.s_dat_o, 32'hDEAD_BEEF);
        check("mux_nonown_adr", bf.s_adr_o, 30'h0000_1234);
        bf.s_ack_i = 1'b1; bf.s_dat_i = 32'hCAFE_F00D;
        #1 check("mux_ack", bf.m_ack_o, 3'b001);
        check("mux_rdat", bf.m_dat_o, 32'hCAFE_F00D);
        bf.s_ack_i = 1'b0; bf.s_err_i = 1'b1;
        #1 check("mux_err", bf.m_err_o, 3'b001);
        bf.s_err_i = 1'b0;
        bf.req_i = '0; bf.m_cyc_i = '0; bf.m_stb_i = '0; bf.m_we_i = '0;
        step(1);
        check("mux_rel", bf.grant_o, 3'b000);

        // ---- cyc without grant, all reqs low: stays idle and quiet
        bf.m_cyc_i = 3'b100; bf.m_stb_i = 3'b100;
        step(2);
        check("nogr_grant", bf.grant_o, 3'b000);
        check("nogr_scyc",  bf.s_cyc_o, 1'b0);
        check("nogr_sstb",  bf.s_stb_o, 1'b0);
        bf.m_cyc_i = '0; bf.m_stb_i = '0;

        // ---- mid-transfer req drop: grant held until cyc drops
        bf.req_i = 3'b010; bf.m_cyc_i = 3'b010; bf.m_stb_i = 3'b010;
        step(1);
        check("mid_grant", bf.grant_o, 3'b010);
        bf.req_i = 3'b000;
        step(1);
        check("mid_hold1", bf.grant_o, 3'b010);
        step(2);
        check("mid_hold3", bf.busy_o, 1'b1);
        bf.s_ack_i = 1'b1;
        #1 check("mid_ack", bf.m_ack_o, 3'b010);
        bf.s_ack_i = 1'b0; bf.m_cyc_i = '0; bf.m_stb_i = '0;
        step(1);
        check("mid_rel", bf.grant_o, 3'b000);

        // ---- round robin N=3: order 0,1,2,0 with a dead cycle each time
        br.req_i = 3'b111; br.m_cyc_i = 3'b111; br.m_stb_i = 3'b111;
        step(1);
        for (int t = 0; t < 4; t++) begin
            int k;
            k = t % 3;
            check("rr_grant", br.grant_o, 64'(3'b001 << k));
            check("rr_owner", br.owner_o, 64'(k));
            step(3);
            check("rr_nopreempt", br.grant_o, 64'(3'b001 << k));
            br.req_i[k] = 1'b0; br.m_cyc_i[k] = 1'b0;
            step(1);
            check("rr_dead", br.grant_o, 3'b000);
            if (t != 3) begin
                br.req_i[k] = 1'b1; br.m_cyc_i[k] = 1'b1;
                step(1);
            end
        end
        br.req_i = '0; br.m_cyc_i = '0; br.m_stb_i = '0;
        step(1);

`ifdef RV32IM_ARB_WATCHDOG_EN
        // ---- watchdog: rr_ptr is 1 here, owner 2 stalls 8 cycles
        br.req_i = 3'b100; br.m_cyc_i = 3'b100; br.m_stb_i = 3'b100;
        step(1);
        check("wd_grant", br.grant_o, 3'b100);
        step(6);
        check("wd_early_to",  to_rr, 1'b0);
        check("wd_early_err", br.m_err_o, 3'b000);
        step(1);
        check("wd_to",  to_rr, 1'b1);
        check("wd_err", br.m_err_o, 3'b100);
        step(1);
        check("wd_idle", br.grant_o, 3'b000);
        check("wd_to_off", to_rr, 1'b0);
        br.req_i = 3'b101; br.m_cyc_i = 3'b101;
        step(1);
        check("wd_ptr0", br.grant_o, 3'b001);
        br.req_i = '0; br.m_cyc_i = '0; br.m_stb_i = '0;
        step(1);
`endif

        // ---- round robin N=5: pointer advance and wrap 4 -> 0
        b5.req_i = 5'b00100; b5.m_cyc_i = 5'b00100;
        step(1);
        check("rr5_g2", b5.grant_o, 5'b00100);
        b5.req_i = '0; b5.m_cyc_i = '0;
        step(1);
        check("rr5_dead1", b5.grant_o, 5'b00000);
        b5.req_i = 5'b10011; b5.m_cyc_i = 5'b10011;
        step(1);
        check("rr5_g4",   b5.grant_o, 5'b10000);
        check("rr5_own4", b5.owner_o, 3'd4);
        b5.req_i = '0; b5.m_cyc_i = '0;
        step(1);
        check("rr5_dead2", b5.grant_o, 5'b00000);
        b5.req_i = 5'b10010; b5.m_cyc_i = 5'b10010;
        step(1);
        check("rr5_wrap", b5.grant_o, 5'b00010);
        b5.req_i = '0; b5.m_cyc_i = '0;
        step(1);

        // ---- reset mid-transfer abandons the cycle
        bf.req_i = 3'b001; bf.m_cyc_i = 3'b001; bf.m_stb_i = 3'b001;
        step(1);
        check("rstm_grant", bf.grant_o, 3'b001);
        check("rstm_stb",   bf.s_stb_o, 1'b1);
        rst_n = 1'b0;
        step(1);
        check("rstm_g0",   bf.grant_o, 3'b000);
        check("rstm_scyc", bf.s_cyc_o, 1'b0);
        bf.s_ack_i = 1'b1;
        #1 check("rstm_ack", bf.m_ack_o, 3'b000);
        clr_all();
        rst_n = 1'b1;
        step(1);
        check("rstm_after", bf.grant_o, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
